// File: rtl/stage_3_pair_issuer.sv
// Pairs incoming float words, queues the pairs and issues one stage_4 addition per pair.
// Optional watchdog: define STAGE3_TIMEOUT_EN to drop a pair stage_4 never completes.
module stage_3_pair_issuer #(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int PTR_WIDTH        = 2,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        in_valid,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        s4_start,
  output logic [FLOAT_DATA_WIDTH-1:0] s4_current_total,
  output logic [FLOAT_DATA_WIDTH-1:0] s4_to_add_one,
  output logic [FLOAT_DATA_WIDTH-1:0] s4_to_add_two,
  input  logic                        s4_done,
  input  logic [FLOAT_DATA_WIDTH-1:0] s4_new_total,
  output logic [FLOAT_DATA_WIDTH-1:0] total,
  output logic                        total_valid,
  output logic                        busy,
  output logic                        error
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [PTR_WIDTH:0] LP_FULL = (PTR_WIDTH+1)'(FIFO_DEPTH);

  state_t                      r_state;
  logic [FLOAT_DATA_WIDTH-1:0] r_fifo_one  [FIFO_DEPTH];
  logic [FLOAT_DATA_WIDTH-1:0] r_fifo_two  [FIFO_DEPTH];
  logic                        r_fifo_last [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]        r_wr_ptr;
  logic [PTR_WIDTH-1:0]        r_rd_ptr;
  logic [PTR_WIDTH:0]          r_count;
  logic [FLOAT_DATA_WIDTH-1:0] r_hold;
  logic                        r_hold_valid;
  logic [FLOAT_DATA_WIDTH-1:0] r_running_total;
  logic [FLOAT_DATA_WIDTH-1:0] r_total;
  logic                        r_total_valid;
  logic                        r_start;
  logic [FLOAT_DATA_WIDTH-1:0] r_cur;
  logic [FLOAT_DATA_WIDTH-1:0] r_one;
  logic [FLOAT_DATA_WIDTH-1:0] r_two;

  logic                        w_accept;
  logic                        w_push;
  logic                        w_done;
  logic                        w_timeout;
  logic                        w_pop;
  logic                        w_head_last;
  logic [FLOAT_DATA_WIDTH-1:0] w_push_one;
  logic [FLOAT_DATA_WIDTH-1:0] w_push_two;

  assign in_ready    = (r_count != LP_FULL);
  assign w_accept    = clk_en && in_valid && in_ready;
  assign w_push      = w_accept && (r_hold_valid || in_last);
  assign w_done      = clk_en && (r_state == ST_WAIT) && s4_done;
  assign w_pop       = w_done || w_timeout;
  assign w_head_last = r_fifo_last[r_rd_ptr];
  // A lone last word is padded with +0.0 so every queued entry is a full pair.
  assign w_push_one  = r_hold_valid ? r_hold  : in_data;
  assign w_push_two  = r_hold_valid ? in_data : '0;

  assign s4_start         = r_start && clk_en;
  assign total_valid      = r_total_valid && clk_en;
  assign s4_current_total = r_cur;
  assign s4_to_add_one    = r_one;
  assign s4_to_add_two    = r_two;
  assign total            = r_total;
  assign busy             = (r_count != '0) || (r_state != ST_IDLE) || r_hold_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_one[i]  <= '0;
        r_fifo_two[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (clk_en) begin
      if (w_accept) begin
        if (w_push) begin
          r_fifo_one[r_wr_ptr]  <= w_push_one;
          r_fifo_two[r_wr_ptr]  <= w_push_two;
          r_fifo_last[r_wr_ptr] <= in_last;
          r_wr_ptr              <= r_wr_ptr + 1'b1;
          r_hold_valid          <= 1'b0;
        end else begin
          r_hold       <= in_data;
          r_hold_valid <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Operands are captured on the way into ISSUE so they stay put until WAIT exits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_running_total <= '0;
      r_total         <= '0;
      r_total_valid   <= 1'b0;
      r_start         <= 1'b0;
      r_cur           <= '0;
      r_one           <= '0;
      r_two           <= '0;
    end else if (clk_en) begin
      r_total_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_count != '0) begin
            r_state <= ST_ISSUE;
            r_start <= 1'b1;
            r_cur   <= r_running_total;
            r_one   <= r_fifo_one[r_rd_ptr];
            r_two   <= r_fifo_two[r_rd_ptr];
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            if (w_head_last) begin
              r_total         <= s4_new_total;
              r_total_valid   <= 1'b1;
              r_running_total <= '0;
            end else begin
              r_running_total <= s4_new_total;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            if (w_head_last) begin
              r_running_total <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

`ifdef STAGE3_TIMEOUT_EN
  localparam int LP_TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [LP_TW-1:0] r_timer;
  logic             r_error;

  assign w_timeout = clk_en && (r_state == ST_WAIT) && !s4_done &&
                     (r_timer == LP_TW'(TIMEOUT_CYCLES - 1));
  assign error     = r_error;

  // The timer idles at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
      r_error <= 1'b0;
    end else if (clk_en) begin
      if (r_state != ST_WAIT) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: doc/stage_3_pair_issuer.md
Name: stage_3_pair_issuer

Overview:
- Upstream neighbour of the final-adder stage_4.
- Collects a stream of IEEE-754 single-precision values from the CORDIC output, groups them into operand pairs and buffers the pairs in a small FIFO.
- Issues one stage_4 addition per pair. It owns the running-total register: current_total is sent out, new_total comes back.
- At the end of a batch it presents the final sum and clears the total for the next batch.

Parameters:
- FLOAT_DATA_WIDTH, 32, width of every data word.
- FIFO_DEPTH, 4, number of buffered operand pairs; must be a power of 2.
- PTR_WIDTH, 2, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable, shared with stage_4. When low, all state is frozen.
- in_valid  in  1  input word valid.
- in_data  in  FLOAT_DATA_WIDTH  input float word.
- in_last  in  1  marks the final word of a batch; qualified by in_valid.
- in_ready  out  1  block can accept a word.
- s4_start  out  1  one-cycle start pulse to stage_4.
- s4_current_total  out  FLOAT_DATA_WIDTH  running total sent to stage_4.
- s4_to_add_one  out  FLOAT_DATA_WIDTH  first operand of the head pair.
- s4_to_add_two  out  FLOAT_DATA_WIDTH  second operand of the head pair.
- s4_done  in  1  stage_4 completion pulse.
- s4_new_total  in  FLOAT_DATA_WIDTH  stage_4 result, valid with s4_done.
- total  out  FLOAT_DATA_WIDTH  final batch sum; held until the next batch completes.
- total_valid  out  1  one-cycle pulse when total updates.
- busy  out  1  high when the FIFO is non-empty, the FSM is not IDLE, or the hold register is occupied.
- error  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous): all registers clear.
  - FSM goes to IDLE; FIFO count, pointers and hold_valid go to 0.
  - Running total goes to 32'h0.
  - s4_start, total_valid, busy and error go to 0; total goes to 32'h0.
- Reset mid-operation discards the hold word, the FIFO contents and the in-flight pair. A stray s4_done arriving after reset while in IDLE is ignored.
- clk_en=0: no state changes and no word is accepted. s4_start and total_valid are forced to 0.
- Input handshake: a word is accepted on a clk_en && in_valid && in_ready cycle. in_ready is low exactly when count == FIFO_DEPTH; it is combinational from count.
- Pairing:
  - An accepted word with hold_valid=0 and in_last=0 goes to the hold register and sets hold_valid.
  - An accepted word with hold_valid=1 pushes {hold, word, in_last} and clears hold_valid.
  - An accepted word with hold_valid=0 and in_last=1 pushes {word, 32'h0, 1}. +0.0 is the pad value.
- FIFO: circular buffer of pairs, each entry carrying a last flag. Pointers wrap modulo FIFO_DEPTH. The head stays in the FIFO until its addition completes.
  - Pop occurs on the s4_done cycle in WAIT.
  - A push and a pop in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when count != 0.
  - ISSUE: s4_start=1 for exactly one cycle, then the FSM moves to WAIT.
  - WAIT -> IDLE on s4_done. On that cycle:
    - running total <= s4_new_total; pop the head pair.
    - If the head's last flag is set: total <= s4_new_total, total_valid=1 next cycle, running total <= 32'h0.
  - s4_current_total, s4_to_add_one and s4_to_add_two are registered from the running total and the FIFO head. They stay stable from ISSUE until the WAIT exit.
- Latency:
  - With the FSM in IDLE and the FIFO empty, s4_start rises 2 cycles after the pushing word is accepted.
  - Back-to-back pairs: the next s4_start follows 2 cycles after s4_done.
  - total_valid rises 1 cycle after the s4_done of the last pair.
- s4_done while in IDLE or ISSUE is ignored.

Optional Feature:
- Macro: STAGE3_TIMEOUT_EN.
- Defined: a counter runs in WAIT and clears on entry to WAIT. If it reaches TIMEOUT_CYCLES without s4_done:
  - error is set (sticky until reset);
  - the head pair is popped and dropped;
  - the running total is unchanged, or cleared to 0 if the dropped pair carried last; total_valid is not pulsed;
  - the FSM returns to IDLE.
- Not defined: no counter logic; error is tied to 0 and WAIT waits indefinitely.

Test Plan:
- Batch sum: words 1.0, 2.0, 3.0, 4.0 (last on 4.0) against a stage_4 model (sum = total + one + two). Required response: two s4_start pulses; the second has s4_current_total=32'h40400000; total=32'h41200000 with a single total_valid pulse; then the running total is 0.
- Odd batch: single word 1.5 with last. Required response: s4_to_add_one=32'h3FC00000, s4_to_add_two=32'h0, total=32'h3FC00000.
- Backpressure: stage_4 model never asserts done; stream 10 words. Required response: in_ready falls after the 8th word is accepted (count=4); exactly one s4_start is seen; raising done drains the FIFO with one start per pair.
- Reset mid-WAIT: drop rst during WAIT, then release it and pulse s4_done. Required response: all outputs are 0, total_valid stays 0, and the FSM stays in IDLE.
- clk_en freeze: hold clk_en=0 for 5 cycles while in ISSUE with in_valid=1. Required response: no s4_start, no word accepted, state is retained; s4_start fires in the first cycle after clk_en returns to 1.
- Timeout (with STAGE3_TIMEOUT_EN): no done for 64 cycles. Required response: error=1, head pair dropped, FSM in IDLE, next pair issued normally.
